// File: rtl/mont_to_form.sv
// rtl/mont_to_form.sv - converts a into Montgomery form (a * 2^LEN mod n) by LEN modular doublings
module mont_to_form #(
  parameter int LEN = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [LEN-1:0] res
);

  localparam int CW = $clog2(LEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0] acc_q, acc_d;
  logic [LEN-1:0] n_q, n_d;
  logic [LEN-1:0] res_q, res_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           in_bad;
  logic [LEN:0]   dbl;
  logic [LEN:0]   n_ext;

  always_comb begin
    in_bad  = !n[0] || (n < LEN'(3)) || (a >= n);
    dbl     = {acc_q, 1'b0};
    n_ext   = {1'b0, n_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    n_d     = n_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d = n;
          if (in_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
            res_d   = '0;
          end else begin
            acc_d   = a;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // acc < n is invariant, so 2*acc < 2n and one subtract brings it back below n
        acc_d = (dbl >= n_ext) ? LEN'(dbl - n_ext) : dbl[LEN-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LEN - 1)) begin
          res_d   = acc_d;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign res  = res_q;

endmodule

// File: tb/tb_mont_to_form.sv
// tb/tb_mont_to_form.sv - scoreboard bench for mont_to_form at LEN=256 and LEN=8
module tb_mont_to_form;

  typedef struct {
    logic         err;
    logic [255:0] res;
    int           cyc;
  } exp_t;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] P_M1_R =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFD_FFFFF85E;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic         rst_n_b, start_b, busy_b, done_b, err_b;
  logic [255:0] a_b, n_b, res_b;
  logic         rst_n_s, start_s, busy_s, done_s, err_s;
  logic [7:0]   a_s, n_s, res_s;

  mont_to_form #(.LEN(256)) u_big (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .a(a_b), .n(n_b),
    .busy(busy_b), .done(done_b), .err(err_b), .res(res_b)
  );

  mont_to_form #(.LEN(8)) u_small (
    .clk(clk), .rst_n(rst_n_s), .start(start_s), .a(a_s), .n(n_s),
    .busy(busy_s), .done(done_s), .err(err_s), .res(res_s)
  );

  exp_t qb[$];
  exp_t qs[$];
  exp_t eb, es;
  bit   idle_chk_b = 1'b0;
  bit   idle_chk_s = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s", nm);
  endtask

  // Reference: a * 2^len mod n in plain wide arithmetic, or an error result
  function automatic exp_t model(input logic [255:0] aa, input logic [255:0] nn,
                                 input int len, input int k);
    exp_t e;
    logic [511:0] x;
    if (nn[0] == 1'b0 || nn < 256'd3 || aa >= nn) begin
      e.err = 1'b1;
      e.res = '0;
      e.cyc = k;
    end else begin
      x = {256'b0, aa} << len;
      x = x % {256'b0, nn};
      e.err = 1'b0;
      e.res = x[255:0];
      e.cyc = k + len;
    end
    return e;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    if (idle_chk_b) begin
      chk("big busy after done", 256'(busy_b), 256'd0);
      idle_chk_b = 1'b0;
    end
    if (done_b) begin
      if (qb.size() == 0) fail_now("big unexpected done");
      else begin
        eb = qb.pop_front();
        chk("big res", res_b, eb.res);
        chk("big err", 256'(err_b), 256'(eb.err));
        chk("big done cycle", 256'(cyc), 256'(eb.cyc));
      end
      idle_chk_b = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (idle_chk_s) begin
      chk("small busy after done", 256'(busy_s), 256'd0);
      idle_chk_s = 1'b0;
    end
    if (done_s) begin
      if (qs.size() == 0) fail_now("small unexpected done");
      else begin
        es = qs.pop_front();
        chk("small res", 256'(res_s), es.res);
        chk("small err", 256'(err_s), 256'(es.err));
        chk("small done cycle", 256'(cyc), 256'(es.cyc));
      end
      idle_chk_s = 1'b1;
    end
  end

  task automatic start_big(input logic [255:0] aa, input logic [255:0] nn,
                           input bit use_ref, input logic [255:0] rr);
    exp_t e;
    @(negedge clk);
    a_b = aa; n_b = nn; start_b = 1'b1;
    e = model(aa, nn, 256, cyc + 1);
    if (use_ref) e.res = rr;
    qb.push_back(e);
    @(negedge clk); #1;
    start_b = 1'b0; a_b = rand256(); n_b = rand256();
  endtask

  task automatic wait_big();
    for (int i = 0; i < 300 && qb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (qb.size() != 0) begin
      fail_now("big done timeout");
      qb.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic start_small(input logic [7:0] aa, input logic [7:0] nn,
                             input bit use_ref, input logic [7:0] rr);
    exp_t e;
    @(negedge clk);
    a_s = aa; n_s = nn; start_s = 1'b1;
    e = model(256'(aa), 256'(nn), 8, cyc + 1);
    if (use_ref) e.res = 256'(rr);
    qs.push_back(e);
    @(negedge clk); #1;
    start_s = 1'b0; a_s = 8'($urandom); n_s = 8'($urandom);
  endtask

  task automatic wait_small();
    for (int i = 0; i < 40 && qs.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (qs.size() != 0) begin
      fail_now("small done timeout");
      qs.delete();
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] nn;
    logic [7:0]   an, nn8;
    rst_n_b = 1'b0; start_b = 1'b0; a_b = '0; n_b = '0;
    rst_n_s = 1'b0; start_s = 1'b0; a_s = '0; n_s = '0;
    repeat (3) @(negedge clk);
    chk("big reset busy", 256'(busy_b), 256'd0);
    chk("big reset done", 256'(done_b), 256'd0);
    chk("big reset err", 256'(err_b), 256'd0);
    chk("big reset res", res_b, 256'd0);
    chk("small reset busy", 256'(busy_s), 256'd0);
    chk("small reset done", 256'(done_s), 256'd0);
    chk("small reset err", 256'(err_s), 256'd0);
    chk("small reset res", 256'(res_s), 256'd0);
    rst_n_b = 1'b1; rst_n_s = 1'b1;

    start_big(256'd1, P256, 1'b1, 256'h1_000003D1);          wait_big();
    start_big(256'd2, P256, 1'b1, 256'h2_000007A2);          wait_big();
    start_big(256'd0, P256, 1'b1, 256'd0);                   wait_big();
    start_big(P256 - 256'd1, P256, 1'b1, P_M1_R);            wait_big();
    start_big(P256, P256, 1'b0, '0);                         wait_big();
    start_big(256'd1, P256 - 256'd1, 1'b0, '0);              wait_big();
    start_big(256'd0, 256'd1, 1'b0, '0);                     wait_big();
    for (int i = 0; i < 5; i++) begin
      nn = rand256() | 256'd1;
      start_big(rand256() % nn, nn, 1'b0, '0);
      wait_big();
    end
    nn = rand256() | 256'd1;
    start_big(nn + 256'd0, nn, 1'b0, '0);                    wait_big();
    nn = rand256() & ~256'd1;
    start_big(256'd3, nn, 1'b0, '0);                         wait_big();

    // start pulses while busy must be dropped
    start_small(8'd5, 8'd13, 1'b1, 8'd6);
    @(negedge clk); a_s = 8'd7; start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    repeat (2) @(negedge clk);
    a_s = 8'd7; start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    wait_small();
    repeat (3) @(negedge clk);
    chk("small res held after ignored starts", 256'(res_s), 256'd6);
    start_small(8'd7, 8'd13, 1'b1, 8'd11); wait_small();

    // reset mid-run abandons the operation with no done
    start_small(8'd5, 8'd13, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst_n_s = 1'b0;
    qs.delete();
    @(negedge clk); #1;
    rst_n_s = 1'b1;
    chk("small busy after reset", 256'(busy_s), 256'd0);
    chk("small res after reset", 256'(res_s), 256'd0);
    chk("small done after reset", 256'(done_s), 256'd0);
    repeat (12) @(negedge clk);
    start_small(8'd5, 8'd13, 1'b1, 8'd6); wait_small();

    for (int i = 0; i < 24; i++) begin
      nn8 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0 || nn8 == 8'd0) an = 8'($urandom_range(0, 255));
      else an = 8'($urandom % 32'(nn8));
      start_small(an, nn8, 1'b0, '0);
      wait_small();
    end

    repeat (4) @(negedge clk);
    if (qb.size() != 0 || qs.size() != 0) fail_now("scoreboard not drained");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
